// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: buffers one frame and streams it in raster order.
// Define ZERO_PAD_EN to wrap the stream in a PAD-wide zero border.
module pixel_stream_feeder #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int DATA_BITS  = 8,
  parameter int ADDR_BITS  = 10,
  parameter int PAD        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 start,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 last_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
  localparam int IW    = $clog2(DEPTH);
`ifdef ZERO_PAD_EN
  localparam int BORDER = PAD;
`else
  localparam int BORDER = PAD * 0;
`endif
  localparam int FW = IMG_WIDTH + 2 * BORDER;
  localparam int FH = IMG_HEIGHT + 2 * BORDER;

  localparam logic [ADDR_BITS-1:0] COL_MAX = ADDR_BITS'(FW - 1);
  localparam logic [ADDR_BITS-1:0] ROW_MAX = ADDR_BITS'(FH - 1);
  localparam logic [ADDR_BITS:0]   DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, PREFETCH, STREAM, DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_q;
  logic [ADDR_BITS-1:0] row, col, rd_addr;
  logic rd_valid, rd_last, more;
  logic adv, fetch, hit, at_end;
  logic in_range, wr_ok, wr_bad;
  logic start_ok, start_bad;

  assign busy = (state == PREFETCH) || (state == STREAM);
  assign done = (state == DONE);

  assign in_range  = {1'b0, wr_addr} < DEPTH_L;
  assign wr_ok     = wr_en && !busy && in_range;
  assign wr_bad    = wr_en && (busy || !in_range);
  assign start_ok  = start && (state == IDLE);
  assign start_bad = start && (state != IDLE);

  // rd_q is a one-deep skid ahead of the output register
  assign adv    = (state == STREAM) && (!valid_out || ready_in);
  assign fetch  = (state == PREFETCH) || (adv && more);
  assign at_end = (row == ROW_MAX) && (col == COL_MAX);

`ifdef ZERO_PAD_EN
  localparam logic [ADDR_BITS-1:0] R_LO = ADDR_BITS'(BORDER);
  localparam logic [ADDR_BITS-1:0] R_HI = ADDR_BITS'(BORDER + IMG_HEIGHT);
  localparam logic [ADDR_BITS-1:0] C_LO = ADDR_BITS'(BORDER);
  localparam logic [ADDR_BITS-1:0] C_HI = ADDR_BITS'(BORDER + IMG_WIDTH);

  assign hit = (row >= R_LO) && (row < R_HI) &&
               (col >= C_LO) && (col < C_HI);
`else
  assign hit = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = PREFETCH;
      PREFETCH: state_nx = STREAM;
      STREAM:   if (valid_out && ready_in && last_out)
                  state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Buffer has no reset so a loaded frame survives rst_n
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_data;
    if (fetch) rd_q <= hit ? mem[rd_addr[IW-1:0]] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      rd_addr   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      more      <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_bad || start_bad) err <= 1'b1;
      else if (start_ok)       err <= 1'b0;
      if (start_ok) begin
        row       <= '0;
        col       <= '0;
        rd_addr   <= '0;
        rd_valid  <= 1'b0;
        more      <= 1'b1;
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end
      if (adv) begin
        data_out  <= rd_q;
        valid_out <= rd_valid;
        last_out  <= rd_last && rd_valid;
        rd_valid  <= 1'b0;
      end
      if (fetch) begin
        rd_valid <= 1'b1;
        rd_last  <= at_end;
        more     <= !at_end;
        if (hit) rd_addr <= rd_addr + 1'b1;
        if (col == COL_MAX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// tb_pixel_stream_feeder: directed bench for a 28x28 and a 4x3 instance.
// Expected beats follow ZERO_PAD_EN when the macro is defined.
module tb_pixel_stream_feeder;

  localparam int BW = 28;
  localparam int BH = 28;
  localparam int SW = 4;
  localparam int SH = 3;
`ifdef ZERO_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int BT = (BW + 2 * P) * (BH + 2 * P);
  localparam int ST = (SW + 2 * P) * (SH + 2 * P);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       b_wr_en = 0, b_start = 0, b_ready = 0;
  logic [9:0] b_wr_addr = '0;
  logic [7:0] b_wr_data = '0, b_data;
  logic       b_valid, b_last, b_busy, b_done, b_err;

  logic       s_wr_en = 0, s_start = 0, s_ready = 0;
  logic [3:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0, s_data;
  logic       s_valid, s_last, s_busy, s_done, s_err;

  pixel_stream_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .start(b_start), .ready_in(b_ready),
    .data_out(b_data), .valid_out(b_valid), .last_out(b_last),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  pixel_stream_feeder #(
    .IMG_WIDTH(SW), .IMG_HEIGHT(SH), .DATA_BITS(8), .ADDR_BITS(4), .PAD(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .start(s_start), .ready_in(s_ready),
    .data_out(s_data), .valid_out(s_valid), .last_out(s_last),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       exp_err;
  } wvec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  wvec_t      wv [13];
  beat_t      bt [ST];
  logic [7:0] s_img [SW*SH];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int src_idx(int k, int w, int h, int p);
    int fw, r, c;
    fw = w + 2 * p;
    r = k / fw;
    c = k % fw;
    if (r < p || r >= p + h || c < p || c >= p + w) return -1;
    return (r - p) * w + (c - p);
  endfunction

  task automatic fill_table();
    int si;
    for (int k = 0; k < ST; k++) begin
      si = src_idx(k, SW, SH, P);
      bt[k].data = (si < 0) ? 8'h00 : s_img[si];
      bt[k].last = (k == ST - 1);
    end
  endtask

  task automatic run_big(input bit toggle, input bit inject,
                         input int abort_at, input bit exp_err);
    int idx = 0, cyc = 0, first = 0, si;
    bit stalled = 0, inj1 = 0, inj2 = 0;
    logic [7:0] hold_d = '0, ed;
    logic hold_l = 0, el;
    @(negedge clk);
    b_start = 1;
    b_ready = 1;
    while (idx < BT && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      b_start = 0;
      b_wr_en = 0;
      if (cyc == 1) begin
        check("busy_prefetch", int'(b_busy), 1);
        check("err_cleared", int'(b_err), 0);
      end
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 0;
        #1;
        check("abort_valid", int'(b_valid), 0);
        check("abort_busy", int'(b_busy), 0);
        check("abort_last", int'(b_last), 0);
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", int'(b_done), 0);
        end
        rst_n = 1;
        return;
      end
      if (stalled) begin
        check("stall_valid", int'(b_valid), 1);
        check("stall_data", int'(b_data), int'(hold_d));
        check("stall_last", int'(b_last), int'(hold_l));
      end
      if (first != 0 && !toggle) check("no_bubble", int'(b_valid), 1);
      if (b_valid) begin
        if (first == 0) begin
          first = cyc;
          check("first_latency", cyc, 3);
        end
        si = src_idx(idx, BW, BH, P);
        ed = (si < 0) ? 8'h00 : 8'(si % 256);
        el = (idx == BT - 1);
        check("beat_data", int'(b_data), int'(ed));
        check("beat_last", int'(b_last), int'(el));
      end
      b_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      stalled = b_valid && !b_ready;
      hold_d = b_data;
      hold_l = b_last;
      if (inject && idx == 100 && !inj1) begin
        b_start = 1;
        inj1 = 1;
      end
      if (inject && idx == 200 && !inj2) begin
        b_wr_en = 1;
        b_wr_addr = 10'd5;
        b_wr_data = 8'hEE;
        inj2 = 1;
      end
      if (b_valid && b_ready) idx++;
    end
    if (idx < BT) check("stream_timeout", idx, BT);
    @(negedge clk);
    check("done_pulse", int'(b_done), 1);
    check("done_valid", int'(b_valid), 0);
    check("done_busy", int'(b_busy), 0);
    check("done_last", int'(b_last), 0);
    check("err_end", int'(b_err), int'(exp_err));
    @(negedge clk);
    check("done_once", int'(b_done), 0);
  endtask

  task automatic run_small(input bit with_wr);
    int idx = 0, cyc = 0;
    @(negedge clk);
    s_start = 1;
    s_ready = 1;
    if (with_wr) begin
      s_wr_en = 1;
      s_wr_addr = 4'd0;
      s_wr_data = 8'h55;
    end
    while (idx < ST && cyc < 200) begin
      @(negedge clk);
      cyc++;
      s_start = 0;
      s_wr_en = 0;
      if (cyc == 1) check("s_err_cleared", int'(s_err), 0);
      if (cyc < 3) check("s_latency", int'(s_valid), 0);
      else check("s_valid", int'(s_valid), 1);
      if (s_valid) begin
        check("s_data", int'(s_data), int'(bt[idx].data));
        check("s_last", int'(s_last), int'(bt[idx].last));
        idx++;
      end
    end
    if (idx < ST) check("s_timeout", idx, ST);
    @(negedge clk);
    check("s_done", int'(s_done), 1);
    check("s_done_valid", int'(s_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      wv[i] = '{addr: 4'(i), data: 8'(i + 1), exp_err: 1'b0};
      s_img[i] = 8'(i + 1);
    end
    wv[12] = '{addr: 4'd12, data: 8'h99, exp_err: 1'b1};
    fill_table();

    repeat (2) @(negedge clk);
    check("rst_valid", int'(b_valid), 0);
    check("rst_last", int'(b_last), 0);
    check("rst_data", int'(b_data), 0);
    check("rst_busy", int'(b_busy), 0);
    check("rst_done", int'(b_done), 0);
    check("rst_err", int'(b_err), 0);
    check("s_rst_valid", int'(s_valid), 0);
    check("s_rst_err", int'(s_err), 0);
    rst_n = 1;

    for (int i = 0; i < 784; i++) begin
      @(negedge clk);
      b_wr_en = 1;
      b_wr_addr = 10'(i);
      b_wr_data = 8'(i % 256);
    end
    @(negedge clk);
    b_wr_en = 0;
    check("load_err", int'(b_err), 0);

    run_big(0, 0, -1, 0);
    run_big(1, 0, -1, 0);
    run_big(0, 1, -1, 1);
    run_big(0, 0, -1, 0);
    run_big(0, 0, 300, 0);
    run_big(0, 0, -1, 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      s_wr_en = 1;
      s_wr_addr = wv[i].addr;
      s_wr_data = wv[i].data;
      @(negedge clk);
      s_wr_en = 0;
      check("s_wr_err", int'(s_err), int'(wv[i].exp_err));
    end
    run_small(0);
    s_img[0] = 8'h55;
    fill_table();
    run_small(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
